// File: rtl/multi_port_ram.sv
// ---------------------------------------------------------------------------
// multi_port_ram
//
// Purpose:
//   Multi-lane RAM. LANES independent address/data lanes share one
//   request handshake. All enabled lanes of one request are either written
//   or read together. A background zero-fill (CLEAR) sweeps the whole
//   memory one word per cycle. Requests are refused while it runs, but
//   reads already in flight still drain from the read pipeline.
//
// Parameters:
//   DATA_LEN      width of one memory word
//   ADDRESS_LEN   address width per lane, depth = 2**ADDRESS_LEN
//   LANES         number of parallel lanes (1..8)
//   READ_LATENCY  1 or 2 cycles from accepted read to rsp_valid
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    request present
//   req_ready    request can be accepted this cycle
//   req_write    1 = write, 0 = read
//   lane_en      per-lane enable
//   address      packed lane addresses, lane k at [k*ADDRESS_LEN +: ADDRESS_LEN]
//   data_in      packed write data, lane k at [k*DATA_LEN +: DATA_LEN]
//   data_out     packed read data, same packing, held between responses
//   rsp_valid    one-cycle pulse per accepted read
//   clear_start  request zero-fill of the whole memory
//   busy         high while the zero-fill runs
//   collision    one-cycle pulse after a write with two lanes on one address
// ---------------------------------------------------------------------------
module multi_port_ram #(
    parameter int DATA_LEN     = 16,
    parameter int ADDRESS_LEN  = 8,
    parameter int LANES        = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [LANES-1:0]              lane_en,
    input  logic [ADDRESS_LEN*LANES-1:0]  address,
    input  logic [DATA_LEN*LANES-1:0]     data_in,
    output logic [DATA_LEN*LANES-1:0]     data_out,
    output logic                          rsp_valid,
    input  logic                          clear_start,
    output logic                          busy,
    output logic                          collision
);

    localparam int DEPTH = 2 ** ADDRESS_LEN;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                     state;
    logic [ADDRESS_LEN-1:0]     clear_cnt;
    logic [DATA_LEN-1:0]        mem [DEPTH];

    logic                       accept;
    logic                       wr_accept;
    logic                       rd_accept;
    logic                       conflict;
    logic [DATA_LEN*LANES-1:0]  rd_word;

    // ------------------------------------------------------------------
    // Handshake. Holding off req_ready during reset keeps the memory
    // untouched while rst is high. A clear request in the same cycle as
    // a transfer takes priority and the transfer is not accepted.
    // ------------------------------------------------------------------
    assign req_ready = !rst && (state == IDLE) && !clear_start;
    assign accept    = req_valid && req_ready;
    assign wr_accept = accept && req_write;
    assign rd_accept = accept && !req_write;

    // ------------------------------------------------------------------
    // Zero-fill control. The counter starts at 0 on entry and the FSM
    // returns to IDLE on the edge that writes the last address, giving
    // exactly DEPTH busy cycles. clear_start is not looked at in CLEAR,
    // so a second pulse cannot restart the sweep.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clear_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state     <= CLEAR;
                        clear_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clear_cnt == {ADDRESS_LEN{1'b1}}) begin
                        state     <= IDLE;
                        clear_cnt <= '0;
                        busy      <= 1'b0;
                    end else begin
                        clear_cnt <= clear_cnt + ADDRESS_LEN'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    clear_cnt <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Same-address detection across every pair of enabled lanes.
    // ------------------------------------------------------------------
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (lane_en[i] && lane_en[j] &&
                    (address[i*ADDRESS_LEN +: ADDRESS_LEN] ==
                     address[j*ADDRESS_LEN +: ADDRESS_LEN])) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision <= 1'b0;
        end else begin
            collision <= wr_accept && conflict;
        end
    end

    // ------------------------------------------------------------------
    // Memory array. It has no reset, so reset leaves the contents alone,
    // including a sweep interrupted part way through. Lanes are written
    // in ascending order so the highest-index lane wins a same-address
    // conflict.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && (state == CLEAR)) begin
            mem[clear_cnt] <= '0;
        end else if (wr_accept) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_en[k]) begin
                    mem[address[k*ADDRESS_LEN +: ADDRESS_LEN]] <=
                        data_in[k*DATA_LEN +: DATA_LEN];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read word as the memory stands before the acceptance edge.
    // Disabled lanes read as zero.
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_en[k]) begin
                rd_word[k*DATA_LEN +: DATA_LEN] =
                    mem[address[k*ADDRESS_LEN +: ADDRESS_LEN]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. One read can enter per cycle. The pipeline ignores
    // the FSM state, so reads accepted before a clear still drain.
    // data_out only updates on a response and holds otherwise.
    // ------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                      s1_valid;
            logic [DATA_LEN*LANES-1:0] s1_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid  <= 1'b0;
                    s1_data   <= '0;
                    rsp_valid <= 1'b0;
                    data_out  <= '0;
                end else begin
                    s1_valid  <= rd_accept;
                    if (rd_accept) begin
                        s1_data <= rd_word;
                    end
                    rsp_valid <= s1_valid;
                    if (s1_valid) begin
                        data_out <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rsp_valid <= 1'b0;
                    data_out  <= '0;
                end else begin
                    rsp_valid <= rd_accept;
                    if (rd_accept) begin
                        data_out <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: doc/multi_port_ram.md
MULTI_PORT_RAM -- requirements
Module: multi_port_ram

Interface
REQ-001 SHALL have parameter DATA_LEN, default 16, width of one memory word.
REQ-002 SHALL have parameter ADDRESS_LEN, default 8, address width per lane; depth = 2**ADDRESS_LEN.
REQ-003 SHALL have parameter LANES, default 3, number of parallel access lanes, legal 1..8.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from accepted read to rsp_valid.
REQ-005 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1, request present.
REQ-008 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-009 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port lane_en, input, LANES, per-lane enable.
REQ-011 SHALL have port address, input, ADDRESS_LEN*LANES, lane k at bits [k*ADDRESS_LEN +: ADDRESS_LEN].
REQ-012 SHALL have port data_in, input, DATA_LEN*LANES, lane k at bits [k*DATA_LEN +: DATA_LEN].
REQ-013 SHALL have port data_out, output, DATA_LEN*LANES, read data, same lane packing.
REQ-014 SHALL have port rsp_valid, output, 1, data_out valid, one-cycle pulse per accepted read.
REQ-015 SHALL have port clear_start, input, 1, request zero-fill of whole memory.
REQ-016 SHALL have port busy, output, 1, high while zero-fill runs.
REQ-017 SHALL have port collision, output, 1, one-cycle pulse on same-address write conflict.

Function
REQ-018 Request SHALL be accepted when req_valid and req_ready are both high on a rising clk edge.
REQ-019 req_ready SHALL be high only when state is IDLE and clear_start is low.
REQ-020 FSM states SHALL be IDLE and CLEAR: IDLE->CLEAR on clear_start; CLEAR->IDLE after the write to address 2**ADDRESS_LEN-1.
REQ-021 In CLEAR, a counter starting at 0 SHALL write zero to one address per cycle, taking exactly 2**ADDRESS_LEN cycles; busy high throughout.
REQ-022 clear_start together with req_valid in IDLE SHALL start the clear and SHALL NOT accept the request.
REQ-023 clear_start while in CLEAR SHALL be ignored; the counter SHALL NOT restart.
REQ-024 Accepted write SHALL store each enabled lane's data_in slice at that lane's address; disabled lanes SHALL write nothing.
REQ-025 If two or more enabled lanes write the same address, the highest-index lane's data SHALL be stored, and collision SHALL pulse high on the following cycle.
REQ-026 Accepted read SHALL return, after READ_LATENCY cycles, each enabled lane's word at its address; disabled lanes' slices SHALL be zero.
REQ-027 Read data SHALL reflect memory as it stood at the acceptance edge; the read pipeline SHALL accept one read per cycle back to back.
REQ-028 A read to the same address as a write accepted the previous cycle SHALL return the newly written data.
REQ-029 data_out SHALL hold its last value when rsp_valid is low.
REQ-030 Reads SHALL always be allowed to drain from the pipeline while CLEAR runs; rsp_valid SHALL still pulse for them.
REQ-031 Addresses SHALL wrap naturally within ADDRESS_LEN bits; no out-of-range case exists.

Reset
REQ-032 While rst is high: state IDLE, clear counter 0, busy 0, collision 0, rsp_valid 0, pipeline flushed, data_out 0; req_ready goes high after rst falls.
REQ-033 Reset SHALL NOT alter memory contents; reset mid-CLEAR leaves memory partially cleared and returns to IDLE.

Verification
REQ-034 Write lanes 0..2 = 0x0011, 0x0022, 0x0033 at addresses 5, 6, 7; then read 7, 5, 6 -> data_out = {0x0022, 0x0011, 0x0033} with rsp_valid exactly READ_LATENCY cycles after acceptance.
REQ-035 Write lanes 0 and 2 both at address 9 with 0xAAAA and 0xBBBB -> collision pulses once; a read of address 9 returns 0xBBBB.
REQ-036 Read with lane_en = 3'b010 -> lanes 0 and 2 are 0, lane 1 holds stored data.
REQ-037 Pulse clear_start -> busy high for exactly 256 cycles at ADDRESS_LEN = 8, req_ready low throughout; afterwards all addresses read 0.
REQ-038 Assert rst at clear count 100 -> busy drops immediately; address 99 reads 0, address 150 retains its old value.
REQ-039 Run back-to-back reads at READ_LATENCY = 2 with write-then-read to the same address -> one rsp_valid per read, in order, and the read returns the new data.
